axis_pkt_rr_arbiter: RTL and testbench



---
 rtl/axis_pkt_rr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS 512-bit AXI-Stream
// sources onto one sink. A grant is held until its tlast beat transfers.
// Output is registered through a 2-entry (main + skid) buffer. Per-port
// packet and error counters are provided for status readout.
module axis_pkt_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 32,
  localparam int GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_PORTS-1:0]       port_en,
  input  logic [NUM_PORTS-1:0]       s_tvalid,
  input  logic [512*NUM_PORTS-1:0]   s_tdata,
  input  logic [64*NUM_PORTS-1:0]    s_tkeep,
  input  logic [NUM_PORTS-1:0]       s_tlast,
  input  logic [NUM_PORTS-1:0]       s_tuser_err,
  output logic [NUM_PORTS-1:0]       s_tready,
  output logic                       m_tvalid,
  output logic [511:0]               m_tdata,
  output logic [63:0]                m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser_err,
  input  logic                       m_tready,
  output logic [GW-1:0]              grant_idx,
  output logic                       busy,
  output logic [CNT_W*NUM_PORTS-1:0] pkt_cnt,
  output logic [CNT_W*NUM_PORTS-1:0] err_cnt
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_grant_idx;
  logic [GW-1:0]       r_last_grant;

  // Main (output-facing) entry and skid entry
  logic                r_m_valid;
  logic [511:0]        r_m_data;
  logic [63:0]         r_m_keep;
  logic                r_m_last;
  logic                r_m_err;
  logic                r_k_valid;
  logic [511:0]        r_k_data;
  logic [63:0]         r_k_keep;
  logic                r_k_last;
  logic                r_k_err;

  logic [CNT_W-1:0]    r_pkt_cnt [NUM_PORTS];
  logic [CNT_W-1:0]    r_err_cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_found;
  logic [GW-1:0]        w_winner;
  logic                 w_g_valid;
  logic [511:0]         w_g_data;
  logic [63:0]          w_g_keep;
  logic                 w_g_last;
  logic                 w_g_err;
  logic                 w_in_rdy;
  logic                 w_acc;
  logic                 w_drain;

  // Round-robin pick: ports above last_grant first, then wrap to the low ports
  always_comb begin
    w_req    = s_tvalid & port_en;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!w_found && w_req[p] && (GW'(p) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(p);
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!w_found && w_req[p] && (GW'(p) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(p);
      end
    end
  end

  // Select the granted port's beat and steer ready back to it only
  always_comb begin
    w_g_valid = 1'b0;
    w_g_data  = '0;
    w_g_keep  = '0;
    w_g_last  = 1'b0;
    w_g_err   = 1'b0;
    s_tready  = '0;
    w_in_rdy  = (r_state == ST_BUSY) && !r_k_valid;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (r_grant_idx == GW'(p)) begin
        w_g_valid   = s_tvalid[p];
        w_g_data    = s_tdata[512*p +: 512];
        w_g_keep    = s_tkeep[64*p +: 64];
        w_g_last    = s_tlast[p];
        w_g_err     = s_tuser_err[p];
        s_tready[p] = w_in_rdy;
      end
    end
    w_acc   = w_in_rdy && w_g_valid;
    w_drain = r_m_valid && m_tready;
  end

  // Arbitration FSM: IDLE picks a winner, BUSY holds it until tlast is accepted
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= GW'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_idx  <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_acc && w_g_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Skid buffer: input is only accepted while skid is empty, so when skid
  // holds a beat the only possible move is skid -> main on a drain
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_err   <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (r_k_valid) begin
      if (w_drain) begin
        r_m_data  <= r_k_data;
        r_m_keep  <= r_k_keep;
        r_m_last  <= r_k_last;
        r_m_err   <= r_k_err;
        r_k_valid <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_m_valid || w_drain) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_g_data;
        r_m_keep  <= w_g_keep;
        r_m_last  <= w_g_last;
        r_m_err   <= w_g_err;
      end else begin
        r_k_valid <= 1'b1;
        r_k_data  <= w_g_data;
        r_k_keep  <= w_g_keep;
        r_k_last  <= w_g_last;
        r_k_err   <= w_g_err;
      end
    end else if (w_drain) begin
      r_m_valid <= 1'b0;
    end
  end

  // Per-port statistics, counted when the tlast beat is accepted at the input
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_pkt_cnt[p] <= '0;
        r_err_cnt[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_acc && w_g_last && (r_grant_idx == GW'(p))) begin
          r_pkt_cnt[p] <= r_pkt_cnt[p] + CNT_W'(1);
          if (w_g_err) r_err_cnt[p] <= r_err_cnt[p] + CNT_W'(1);
        end
      end
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PORTS; gp++) begin : g_cnt
      assign pkt_cnt[CNT_W*gp +: CNT_W] = r_pkt_cnt[gp];
      assign err_cnt[CNT_W*gp +: CNT_W] = r_err_cnt[gp];
    end
  endgenerate

  assign m_tvalid    = r_m_valid;
  assign m_tdata     = r_m_data;
  assign m_tkeep     = r_m_keep;
  assign m_tlast     = r_m_last;
  assign m_tuser_err = r_m_err;
  assign grant_idx   = r_grant_idx;
  assign busy        = (r_state == ST_BUSY);

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Scoreboard bench for axis_pkt_rr_arbiter: random packets per port, a
// queue-based round-robin reference model, decoupled output monitor.
module tb_axis_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int GW = 2;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         err;
    logic         first;
  } beat_t;

  logic              aclk;
  logic              aresetn;
  logic [N-1:0]      port_en;
  logic [N-1:0]      s_tvalid;
  logic [512*N-1:0]  s_tdata;
  logic [64*N-1:0]   s_tkeep;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tuser_err;
  logic [N-1:0]      s_tready;
  logic              m_tvalid;
  logic [511:0]      m_tdata;
  logic [63:0]       m_tkeep;
  logic              m_tlast;
  logic              m_tuser_err;
  logic              m_tready;
  logic [GW-1:0]     grant_idx;
  logic              busy;
  logic [CW*N-1:0]   pkt_cnt;
  logic [CW*N-1:0]   err_cnt;

  axis_pkt_rr_arbiter #(.NUM_PORTS(N), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .port_en(port_en),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser_err(s_tuser_err), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser_err(m_tuser_err), .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int vecs = 0;
  int errs = 0;

  // Stimulus and model state
  beat_t       src_q [N][$];
  beat_t       m_beats [N][$];
  int          m_lens [N][$];
  beat_t       exp_q [$];
  int          exp_gnt [$];
  int          m_last = N - 1;
  int unsigned m_pkt [N];
  int unsigned m_err [N];
  int          acc_beats = 0;
  bit          drv_flush = 0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_pkt(input int p, input int len, input bit err);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {16{$urandom}};
      b.keep  = {$urandom, $urandom};
      b.first = (i == 0);
      b.last  = (i == len - 1);
      b.err   = b.last ? err : 1'($urandom_range(0, 1));
      src_q[p].push_back(b);
      m_beats[p].push_back(b);
    end
    m_lens[p].push_back(len);
  endtask

  // Reference: whenever the arbiter is free, the next enabled port after the
  // previous winner that still has a packet pending gets the whole packet.
  function automatic void model_run(input logic [N-1:0] en);
    bit    found;
    int    pick;
    int    q;
    int    len;
    beat_t bt;
    do begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        q = (m_last + k) % N;
        if (!found && en[q] && m_lens[q].size() > 0) begin
          found = 1;
          pick  = q;
        end
      end
      if (found) begin
        m_last = pick;
        exp_gnt.push_back(pick);
        len = m_lens[pick].pop_front();
        for (int i = 0; i < len; i++) begin
          bt = m_beats[pick].pop_front();
          exp_q.push_back(bt);
          if (bt.last) begin
            m_pkt[pick]++;
            if (bt.err) m_err[pick]++;
          end
        end
      end
    end while (found);
  endfunction

  task automatic model_clear();
    for (int p = 0; p < N; p++) begin
      m_beats[p].delete();
      m_lens[p].delete();
      m_pkt[p] = 0;
      m_err[p] = 0;
    end
    exp_q.delete();
    exp_gnt.delete();
    m_last = N - 1;
  endtask

  task automatic check_cnts(input string tag);
    for (int p = 0; p < N; p++) begin
      chk({tag, "_pkt_cnt"}, 512'(pkt_cnt[CW*p +: CW]), 512'(m_pkt[p]));
      chk({tag, "_err_cnt"}, 512'(err_cnt[CW*p +: CW]), 512'(m_err[p]));
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL %s_drain: %0d beats still expected after timeout", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge aclk);
    #2;
  endtask

  // Source driver: first beat of a packet is offered immediately, later beats
  // with random gaps; valid holds until the handshake.
  initial begin
    logic [N-1:0] hs;
    beat_t        b;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser_err = '0;
    forever begin
      @(negedge aclk);
      hs = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      if (drv_flush) begin
        for (int p = 0; p < N; p++) src_q[p].delete();
        s_tvalid  = '0;
        drv_flush = 0;
      end else begin
        for (int p = 0; p < N; p++) begin
          if (hs[p] === 1'b1 && src_q[p].size() > 0) begin
            b = src_q[p].pop_front();
            acc_beats++;
            if (b.first) begin
              if (exp_gnt.size() == 0) chk("grant_order_extra", 512'(p), 512'(N));
              else chk("grant_order", 512'(p), 512'(exp_gnt.pop_front()));
              chk("grant_idx", 512'(grant_idx), 512'(p));
            end
            s_tvalid[p] = 1'b0;
          end
        end
        for (int p = 0; p < N; p++) begin
          if (!s_tvalid[p] && src_q[p].size() > 0) begin
            b = src_q[p][0];
            if (b.first || $urandom_range(0, 3) != 0) begin
              s_tvalid[p]               = 1'b1;
              s_tdata[512*p +: 512]     = b.data;
              s_tkeep[64*p +: 64]       = b.keep;
              s_tlast[p]                = b.last;
              s_tuser_err[p]            = b.err;
            end
          end
        end
      end
    end
  end

  // Downstream ready generator
  initial begin
    int ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          m_tready = (ph == 0 || ph == 3);
          ph = (ph + 1) % 4;
        end
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: ordering/payload scoreboard, stall stability, ready mask
  initial begin
    bit           stall = 0;
    logic [511:0] sv_data;
    logic [65:0]  sv_ctl;
    logic [N-1:0] allowed;
    beat_t        e;
    forever begin
      @(negedge aclk);
      if (stall) begin
        chk("hold_valid", 512'(m_tvalid), 512'(1));
        chk("hold_data", m_tdata, sv_data);
        chk("hold_ctl", 512'({m_tkeep, m_tlast, m_tuser_err}), 512'(sv_ctl));
      end
      stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      sv_data = m_tdata;
      sv_ctl  = {m_tkeep, m_tlast, m_tuser_err};
      if (aresetn === 1'b1) begin
        allowed = '0;
        if (busy === 1'b1) allowed[grant_idx] = 1'b1;
        chk("tready_mask", 512'(s_tready & ~allowed), 512'(0));
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 512'(m_tvalid), 512'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.data);
          chk("out_keep", 512'(m_tkeep), 512'(e.keep));
          chk("out_last", 512'(m_tlast), 512'(e.last));
          chk("out_err", 512'(m_tuser_err), 512'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int t;
    int n;
    int a0;
    logic [N-1:0] en;
    for (int p = 0; p < N; p++) begin
      m_pkt[p] = 0;
      m_err[p] = 0;
    end
    aresetn = 1'b0;
    port_en = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    chk("rst_s_tready", 512'(s_tready), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_grant", 512'(grant_idx), 512'(0));
    chk("rst_m_tlast", 512'(m_tlast), 512'(0));
    chk("rst_m_err", 512'(m_tuser_err), 512'(0));
    chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
    chk("rst_err_cnt", 512'(err_cnt), 512'(0));
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    port_en = 4'hF;
    repeat (2) @(posedge aclk);
    #2;

    // Single 3-beat packet on port 0 with latency check
    rdy_mode = 0;
    gen_pkt(0, 3, 0);
    model_run(port_en);
    t = 0;
    do begin @(negedge aclk); t++; end while (s_tvalid[0] !== 1'b1 && t < 50);
    n = 0;
    do begin @(negedge aclk); n++; end while (m_tvalid !== 1'b1 && n < 50);
    chk("first_latency", 512'(n), 512'(2));
    wait_drain("single");
    check_cnts("single");

    // Fairness: every port offers two 2-beat packets
    for (int p = 0; p < N; p++) begin
      gen_pkt(p, 2, 0);
      gen_pkt(p, 2, 0);
    end
    model_run(port_en);
    wait_drain("fair");
    check_cnts("fair");

    // Backpressure: 10-beat packet on port 1 with ready pattern 1,0,0,1
    rdy_mode = 1;
    gen_pkt(1, 10, 0);
    model_run(port_en);
    wait_drain("bp");
    rdy_mode = 0;
    check_cnts("bp");

    // Enable mask 0101 with every port holding packets, then drain the rest
    port_en = 4'b0101;
    for (int p = 0; p < N; p++) begin
      gen_pkt(p, 2, 0);
      gen_pkt(p, 2, 0);
    end
    model_run(port_en);
    wait_drain("mask");
    check_cnts("mask");
    port_en = 4'hF;
    model_run(port_en);
    wait_drain("unmask");

    // Error flag on port 3's tlast
    gen_pkt(3, 3, 1);
    model_run(port_en);
    wait_drain("err");
    check_cnts("err");

    // Random traffic, random masks and random backpressure
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      en = (r == 7) ? 4'hF : 4'($urandom_range(1, 15));
      port_en = en;
      for (int p = 0; p < N; p++) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) gen_pkt(p, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      model_run(en);
      wait_drain("rand");
    end
    check_cnts("rand");
    rdy_mode = 0;
    repeat (3) @(posedge aclk);
    #2;

    // Reset in the middle of a 5-beat packet
    a0 = acc_beats;
    gen_pkt(2, 5, 0);
    model_run(port_en);
    t = 0;
    while (acc_beats < a0 + 2 && t < 500) begin
      @(posedge aclk);
      #2;
      t++;
    end
    chk("midrst_reached", 512'(acc_beats >= a0 + 2), 512'(1));
    aresetn   = 1'b0;
    drv_flush = 1;
    @(posedge aclk);
    #2;
    model_clear();
    @(negedge aclk);
    chk("midrst_m_tvalid", 512'(m_tvalid), 512'(0));
    chk("midrst_s_tready", 512'(s_tready), 512'(0));
    chk("midrst_busy", 512'(busy), 512'(0));
    check_cnts("midrst");
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    for (int p = N - 1; p >= 0; p--) gen_pkt(p, 2, 0);
    model_run(port_en);
    wait_drain("postrst");
    check_cnts("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
